rle_runctl: RTL
===============

# rle_runctl

Single-clock run-length sequencing controller for the RLE encoder datapath. It accepts a stream of 32-bit color words under a valid/ready handshake, compares each word against the current run color, counts run length, and emits one (color, count) token per run under a second valid/ready handshake. It replaces the delayed-clock sequencing of the existing encoder with a fully synchronous FSM on `clock`, and sits between the pixel source and the compressed-output buffer.

## Interface
- MAXRUN, 255, maximum run length per token (1..255); a longer run is split into multiple tokens.
- clock  in  1  system clock; all state changes on the rising edge.
- sysres  in  1  system reset, synchronous, active-high.
- in_valid  in  1  source presents a color word.
- in_data  in  32  color word.
- in_last  in  1  word is the final word of the frame; qualified by in_valid.
- in_ready  out  1  controller accepts in_data this cycle; combinational from state and output register.
- out_valid  out  1  token register holds a valid token.
- out_color  out  32  token color.
- out_count  out  8  token run length, true count 1..MAXRUN (0 never emitted).
- out_last  out  1  token is the final token of the frame.
- out_ready  in  1  sink consumes the token this cycle.

## Operation
- Transfers: input accepted when in_valid & in_ready; token consumed when out_valid & out_ready.
- Internal state: cur_color[31:0], run[7:0], one token register (out_*), FSM state.
- Token register is free when !out_valid | out_ready.
- IDLE: in_ready=1. On accept, cur_color<=in_data and run<=1; next state is FLUSH if in_last, else RUN.
- RUN: in_ready = token register free.
  - Accept with in_data==cur_color and run<MAXRUN: run<=run+1; next state is FLUSH if in_last, else RUN.
  - Accept with in_data!=cur_color, or run==MAXRUN: load token {cur_color, run, last=0}; cur_color<=in_data; run<=1; next state is FLUSH if in_last, else RUN.
- FLUSH: in_ready=0. When the token register is free, load token {cur_color, run, last=1} and go to IDLE.
- The compare is a full 32-bit equality. run never exceeds MAXRUN and never wraps.
- A frame of N words produces tokens whose counts sum to N. Exactly one token per frame has out_last=1, and it is the final token.

## Timing
- Reset: while sysres=1, in_ready=0. On the edge, state<=IDLE, out_valid<=0, out_color<=0, out_count<=0, out_last<=0, cur_color<=0, run<=0. in_ready=1 in the first cycle after sysres deasserts.
- Reset mid-frame discards the in-progress run and any pending token. No token is emitted for the partial run.
- Token latency: a token appears (out_valid=1) in the cycle after the edge that accepted the run-breaking word. The final token appears the cycle after FLUSH finds the register free, which is 2 cycles after the in_last accept when the sink is ready.
- Simultaneous consume and load: when out_valid & out_ready coincide with a load, the register takes the new token and out_valid stays 1. This gives no bubble, so one token per cycle is sustained.
- Backpressure: while out_valid=1 and out_ready=0, out_color, out_count and out_last hold stable. In RUN, in_ready=0 only in this case. Same-color words therefore also stall; this is intentional, to keep the ready logic simple.
- in_last on a word that both breaks the run and ends the frame: the break token loads on that edge. FLUSH then waits for it to be consumed before loading the count-1 last token.
- Single-word frame: IDLE -> FLUSH -> IDLE, producing one token {color, 1, last=1}.

## Test plan
- Reset, then words A,A,A,B,B(last) with out_ready=1 -> tokens {A,3,0} then {B,2,1}. in_ready=1 throughout except the FLUSH cycle.
- Single word C with in_last, out_ready=1 -> one token {C,1,1} two cycles after the accept. FSM returns to IDLE with in_ready=1.
- 300 identical words D, last on word 300, MAXRUN=255 -> tokens {D,255,0} then {D,45,1}.
- Words A,B,C,D,E(last), no repeats, out_ready held 0 for 5 cycles after the first token -> token {A,1,0} holds stable and in_ready=0 during the stall. After release: {B,1,0},{C,1,0},{D,1,0},{E,1,1}, with no token lost or duplicated.
- Words A,A,B with sysres asserted on the cycle after B is accepted -> out_valid=0 and in_ready=0 during reset, and all outputs are 0. A new frame F(last) after reset yields only {F,1,1}.
- Random colors from a 2-color alphabet, random in_valid/out_ready, 10k frames -> checker reconstructs the input exactly from (color, count), and out_count is never 0 or greater than MAXRUN.

Source files
------------

// File: rtl/rle_runctl.sv
// Run-length sequencer: folds a valid/ready stream of 32-bit colors into (color, count, last) tokens.
// Latency: a break token is visible the cycle after the breaking word is accepted; the frame-final token 2 cycles after the last accept.
// Backpressure: a held token stalls all input in RUN (same-color words included); FLUSH waits for the token register to free.
module rle_runctl #(
    parameter int MAXRUN = 255
) (
    input  logic        clock,
    input  logic        sysres,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_color,
    output logic [7:0]  out_count,
    output logic        out_last,
    input  logic        out_ready
);

    localparam logic [7:0] MAXRUN8 = 8'(MAXRUN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_cur_color;
    logic [7:0]  r_run;
    logic        r_out_valid;
    logic [31:0] r_out_color;
    logic [7:0]  r_out_count;
    logic        r_out_last;

    logic w_free;
    logic w_in_ready;
    logic w_accept;
    logic w_extend;

    // The token register can take a new token if empty or being drained this cycle.
    assign w_free   = !r_out_valid || out_ready;
    assign w_accept = in_valid && w_in_ready;
    // Same color and room left in the run: extend instead of emitting a token.
    assign w_extend = (in_data == r_cur_color) && (r_run < MAXRUN8);

    // Input ready depends only on state and the token register, never on in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        if (!sysres) begin
            case (r_state)
                S_IDLE:  w_in_ready = 1'b1;
                S_RUN:   w_in_ready = w_free;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_color = r_out_color;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;

    // Run tracking FSM and token register; a load in the same cycle as a consume keeps out_valid high.
    always_ff @(posedge clock) begin
        if (sysres) begin
            r_state     <= S_IDLE;
            r_cur_color <= '0;
            r_run       <= '0;
            r_out_valid <= 1'b0;
            r_out_color <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cur_color <= in_data;
                        r_run       <= 8'd1;
                        r_state     <= in_last ? S_FLUSH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_extend) begin
                            r_run <= r_run + 8'd1;
                        end else begin
                            // Accept implies the register is free, so the break token always fits.
                            r_out_valid <= 1'b1;
                            r_out_color <= r_cur_color;
                            r_out_count <= r_run;
                            r_out_last  <= 1'b0;
                            r_cur_color <= in_data;
                            r_run       <= 8'd1;
                        end
                        r_state <= in_last ? S_FLUSH : S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_color <= r_cur_color;
                        r_out_count <= r_run;
                        r_out_last  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
